// File: rtl/axi4_lite_resp_router.sv
// Steers AW/W/AR handshakes of a single AXI4-Lite master to one slave.
// Returns that slave's B/R response, or completes unmapped accesses with DECERR.
module axi4_lite_resp_router #(
   parameter int DATA_WIDTH = 32,
   parameter int SLAVE_NUM  = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [SLAVE_NUM-1:0]             aw_slave_sel,
   input  logic [SLAVE_NUM-1:0]             ar_slave_sel,
   input  logic                             m_awvalid,
   output logic                             m_awready,
   input  logic                             m_wvalid,
   output logic                             m_wready,
   output logic                             m_bvalid,
   input  logic                             m_bready,
   output logic [1:0]                       m_bresp,
   input  logic                             m_arvalid,
   output logic                             m_arready,
   output logic                             m_rvalid,
   input  logic                             m_rready,
   output logic [DATA_WIDTH-1:0]            m_rdata,
   output logic [1:0]                       m_rresp,
   output logic [SLAVE_NUM-1:0]             s_awvalid,
   input  logic [SLAVE_NUM-1:0]             s_awready,
   output logic [SLAVE_NUM-1:0]             s_wvalid,
   input  logic [SLAVE_NUM-1:0]             s_wready,
   input  logic [SLAVE_NUM-1:0]             s_bvalid,
   output logic [SLAVE_NUM-1:0]             s_bready,
   input  logic [2*SLAVE_NUM-1:0]           s_bresp,
   output logic [SLAVE_NUM-1:0]             s_arvalid,
   input  logic [SLAVE_NUM-1:0]             s_arready,
   input  logic [SLAVE_NUM-1:0]             s_rvalid,
   output logic [SLAVE_NUM-1:0]             s_rready,
   input  logic [DATA_WIDTH*SLAVE_NUM-1:0]  s_rdata,
   input  logic [2*SLAVE_NUM-1:0]           s_rresp
);

   localparam int IDX_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP, WR_ERR} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_RESP, RD_ERR} rd_state_t;

   wr_state_t        r_wr_state, w_wr_next;
   rd_state_t        r_rd_state, w_rd_next;
   logic [IDX_W-1:0] r_aw_idx, r_ar_idx;
   logic             r_aw_done, r_w_done, r_ar_done;
   logic [IDX_W-1:0] w_aw_idx, w_ar_idx;
   logic             w_aw_hit, w_ar_hit;

   // Lowest set bit wins when a decoder reports more than one hit.
   always_comb begin
      w_aw_idx = '0;
      w_ar_idx = '0;
      w_aw_hit = |aw_slave_sel;
      w_ar_hit = |ar_slave_sel;
      for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
         if (aw_slave_sel[i]) w_aw_idx = IDX_W'(i);
         if (ar_slave_sel[i]) w_ar_idx = IDX_W'(i);
      end
   end

   // ---------------- write path ----------------
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_state <= WR_IDLE;
         r_aw_idx   <= '0;
         r_aw_done  <= 1'b0;
         r_w_done   <= 1'b0;
      end else begin
         r_wr_state <= w_wr_next;
         if (r_wr_state == WR_IDLE && m_awvalid) r_aw_idx <= w_aw_idx;
         if (m_bvalid && m_bready) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
         end else begin
            if (m_awvalid && m_awready) r_aw_done <= 1'b1;
            if (m_wvalid && m_wready)   r_w_done  <= 1'b1;
         end
      end
   end

   // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
   always_comb begin
      w_wr_next = r_wr_state;
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b0;
      m_bresp   = 2'b00;
      s_awvalid = '0;
      s_wvalid  = '0;
      s_bready  = '0;
      case (r_wr_state)
         WR_IDLE: begin
            if (m_awvalid) w_wr_next = w_aw_hit ? WR_XFER : WR_ERR;
         end
         WR_XFER: begin
            s_awvalid[r_aw_idx] = m_awvalid & ~r_aw_done;
            m_awready           = s_awready[r_aw_idx] & ~r_aw_done;
            s_wvalid[r_aw_idx]  = m_wvalid & ~r_w_done;
            m_wready            = s_wready[r_aw_idx] & ~r_w_done;
            if ((r_aw_done || (m_awvalid && m_awready)) &&
                (r_w_done  || (m_wvalid  && m_wready)))
               w_wr_next = WR_RESP;
         end
         WR_RESP: begin
            m_bvalid           = s_bvalid[r_aw_idx];
            s_bready[r_aw_idx] = m_bready;
            if (m_bvalid) m_bresp = s_bresp[2*r_aw_idx +: 2];
            if (m_bvalid && m_bready) w_wr_next = WR_IDLE;
         end
         WR_ERR: begin
            m_awready = ~r_aw_done;
            m_wready  = ~r_w_done;
            // Response only appears the cycle after the later of AW/W is accepted.
            if (r_aw_done && r_w_done) begin
               m_bvalid = 1'b1;
               m_bresp  = RESP_DECERR;
               if (m_bready) w_wr_next = WR_IDLE;
            end
         end
         default: w_wr_next = WR_IDLE;
      endcase
   end

   // ---------------- read path ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_state <= RD_IDLE;
         r_ar_idx   <= '0;
         r_ar_done  <= 1'b0;
      end else begin
         r_rd_state <= w_rd_next;
         if (r_rd_state == RD_IDLE && m_arvalid) r_ar_idx <= w_ar_idx;
         if (m_rvalid && m_rready)
            r_ar_done <= 1'b0;
         else if (r_rd_state == RD_ERR && m_arvalid && m_arready)
            r_ar_done <= 1'b1;
      end
   end

   always_comb begin
      w_rd_next = r_rd_state;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rresp   = 2'b00;
      s_arvalid = '0;
      s_rready  = '0;
      case (r_rd_state)
         RD_IDLE: begin
            if (m_arvalid) w_rd_next = w_ar_hit ? RD_ADDR : RD_ERR;
         end
         RD_ADDR: begin
            s_arvalid[r_ar_idx] = m_arvalid;
            m_arready           = s_arready[r_ar_idx];
            if (m_arvalid && m_arready) w_rd_next = RD_RESP;
         end
         RD_RESP: begin
            m_rvalid           = s_rvalid[r_ar_idx];
            s_rready[r_ar_idx] = m_rready;
            if (m_rvalid) begin
               m_rdata = s_rdata[DATA_WIDTH*r_ar_idx +: DATA_WIDTH];
               m_rresp = s_rresp[2*r_ar_idx +: 2];
            end
            if (m_rvalid && m_rready) w_rd_next = RD_IDLE;
         end
         RD_ERR: begin
            m_arready = ~r_ar_done;
            if (r_ar_done) begin
               m_rvalid = 1'b1;
               m_rresp  = RESP_DECERR;
               if (m_rready) w_rd_next = RD_IDLE;
            end
         end
         default: w_rd_next = RD_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi4_lite_resp_router.sv
// Directed bench for axi4_lite_resp_router: slaves are driven by hand from one
// initial block; per-slave handshake counters catch stray or duplicate beats.
module tb_axi4_lite_resp_router;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    aw_slave_sel, ar_slave_sel;
   logic            m_awvalid, m_awready, m_wvalid, m_wready;
   logic            m_bvalid, m_bready;
   logic [1:0]      m_bresp;
   logic            m_arvalid, m_arready, m_rvalid, m_rready;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready;
   logic [N-1:0]    s_bvalid, s_bready;
   logic [2*N-1:0]  s_bresp;
   logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
   logic [DW*N-1:0] s_rdata;
   logic [2*N-1:0]  s_rresp;

   int total = 0;
   int bad   = 0;
   int aw_hs  [N] = '{default: 0};
   int w_hs   [N] = '{default: 0};
   int ar_hs  [N] = '{default: 0};
   int awv_cyc[N] = '{default: 0};
   int arv_cyc[N] = '{default: 0};

   axi4_lite_resp_router #(.DATA_WIDTH(DW), .SLAVE_NUM(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_slave_sel(aw_slave_sel), .ar_slave_sel(ar_slave_sel),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_rdata(m_rdata), .m_rresp(m_rresp),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_rdata(s_rdata), .s_rresp(s_rresp)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so negedge sees the values the next edge will use.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (s_awvalid[i] && s_awready[i]) aw_hs[i]++;
            if (s_wvalid[i]  && s_wready[i])  w_hs[i]++;
            if (s_arvalid[i] && s_arready[i]) ar_hs[i]++;
            if (s_awvalid[i]) awv_cyc[i]++;
            if (s_arvalid[i]) arv_cyc[i]++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".m_awready"}, m_awready, 0);
      check({tag, ".m_wready"},  m_wready,  0);
      check({tag, ".m_bvalid"},  m_bvalid,  0);
      check({tag, ".m_bresp"},   m_bresp,   0);
      check({tag, ".m_arready"}, m_arready, 0);
      check({tag, ".m_rvalid"},  m_rvalid,  0);
      check({tag, ".m_rdata"},   m_rdata,   0);
      check({tag, ".m_rresp"},   m_rresp,   0);
      check({tag, ".s_awvalid"}, s_awvalid, 0);
      check({tag, ".s_wvalid"},  s_wvalid,  0);
      check({tag, ".s_bready"},  s_bready,  0);
      check({tag, ".s_arvalid"}, s_arvalid, 0);
      check({tag, ".s_rready"},  s_rready,  0);
   endtask

   task automatic clear_inputs();
      aw_slave_sel = '0; ar_slave_sel = '0;
      m_awvalid = 0; m_wvalid = 0; m_bready = 0; m_arvalid = 0; m_rready = 0;
      s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
      s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0;
   endtask

   initial begin
      // ---- reset with busy-looking inputs: everything must stay 0 ----
      rst_n = 0;
      clear_inputs();
      aw_slave_sel = 4'b0001; ar_slave_sel = 4'b0001;
      m_awvalid = 1; m_wvalid = 1; m_arvalid = 1; m_bready = 1; m_rready = 1;
      s_awready = '1; s_wready = '1; s_bvalid = '1; s_bresp = '1;
      s_arready = '1; s_rvalid = '1; s_rdata = {4{32'hA5A5_5A5A}}; s_rresp = '1;
      #2;
      check_all_zero("reset");
      clear_inputs();
      step(); step();
      rst_n = 1;

      // ---- write to slave 1 ----
      aw_slave_sel = 4'b0010; m_awvalid = 1; m_wvalid = 1; #1;
      check("t1.idle_awready", m_awready, 0);
      check("t1.idle_s_awvalid", s_awvalid, 0);
      step(); #1;
      check("t1.s_awvalid", s_awvalid, 4'b0010);
      check("t1.s_wvalid", s_wvalid, 4'b0010);
      check("t1.awready_wait", m_awready, 0);
      aw_slave_sel = 4'b0100; s_awready = 4'b0010; s_wready = 4'b0010; #1;
      check("t1.awready", m_awready, 1);
      check("t1.wready", m_wready, 1);
      check("t1.sel_ignored", s_awvalid, 4'b0010);
      step();
      m_awvalid = 0; m_wvalid = 0; s_awready = '0; s_wready = '0; aw_slave_sel = '0;
      s_bvalid = 4'b0010; s_bresp = 8'b11_10_00_01; #1;
      check("t1.bvalid", m_bvalid, 1);
      check("t1.bresp", m_bresp, 2'b00);
      check("t1.bready_low", s_bready, 0);
      m_bready = 1; #1;
      check("t1.s_bready", s_bready, 4'b0010);
      step();
      m_bready = 0; s_bvalid = '0; s_bresp = '0; #1;
      check("t1.bvalid_done", m_bvalid, 0);
      check("t1.aw_hs1", aw_hs[1], 1);
      check("t1.w_hs1", w_hs[1], 1);
      check("t1.stray_aw", awv_cyc[0] + awv_cyc[2] + awv_cyc[3], 0);

      // ---- W before AW, slave 2 ----
      aw_slave_sel = 4'b0100; m_wvalid = 1; #1;
      check("t2.wready_idle", m_wready, 0);
      check("t2.s_wvalid_idle", s_wvalid, 0);
      step(); step(); step();
      m_awvalid = 1; #1;
      check("t2.s_awvalid_idle", s_awvalid, 0);
      step();
      s_wready = 4'b0100; #1;
      check("t2.wready", m_wready, 1);
      check("t2.awready_wait", m_awready, 0);
      check("t2.s_wvalid", s_wvalid, 4'b0100);
      check("t2.s_awvalid", s_awvalid, 4'b0100);
      step();
      s_bvalid = 4'b0100; s_bresp = 8'b01_00_11_10; #1;
      check("t2.w_masked", s_wvalid, 0);
      check("t2.wready_masked", m_wready, 0);
      check("t2.b_early", m_bvalid, 0);
      check("t2.s_awvalid_held", s_awvalid, 4'b0100);
      s_awready = 4'b0100; m_wvalid = 0; s_wready = '0; #1;
      check("t2.awready", m_awready, 1);
      step();
      m_awvalid = 0; s_awready = '0; #1;
      check("t2.bvalid", m_bvalid, 1);
      check("t2.bresp", m_bresp, 2'b00);
      m_bready = 1;
      step();
      m_bready = 0; s_bvalid = '0; s_bresp = '0; aw_slave_sel = '0; #1;
      check("t2.bvalid_done", m_bvalid, 0);
      check("t2.aw_hs2", aw_hs[2], 1);
      check("t2.w_hs2", w_hs[2], 1);

      // ---- unmapped read ----
      ar_slave_sel = '0; m_arvalid = 1;
      s_rvalid = '1; s_arready = '1; s_rdata = {4{32'h1234_5678}}; s_rresp = 8'b01_01_01_01; #1;
      check("t3.arready_idle", m_arready, 0);
      step(); #1;
      check("t3.arready", m_arready, 1);
      check("t3.rvalid_early", m_rvalid, 0);
      check("t3.s_arvalid", s_arvalid, 0);
      step();
      m_arvalid = 0; #1;
      check("t3.arready_once", m_arready, 0);
      check("t3.rvalid", m_rvalid, 1);
      check("t3.rdata", m_rdata, 0);
      check("t3.rresp", m_rresp, 2'b11);
      for (int k = 0; k < 5; k++) begin
         step(); #1;
         check("t3.rvalid_hold", m_rvalid, 1);
      end
      check("t3.rresp_hold", m_rresp, 2'b11);
      m_rready = 1; #1;
      check("t3.s_rready", s_rready, 0);
      step();
      m_rready = 0; s_rvalid = '0; s_arready = '0; s_rdata = '0; s_rresp = '0; #1;
      check("t3.rvalid_done", m_rvalid, 0);
      check("t3.rresp_idle", m_rresp, 0);
      check("t3.no_s_arvalid", arv_cyc[0] + arv_cyc[1] + arv_cyc[2] + arv_cyc[3], 0);

      // ---- unmapped write, AW then W ----
      aw_slave_sel = '0; m_awvalid = 1;
      step(); #1;
      check("t4.awready", m_awready, 1);
      check("t4.wready", m_wready, 1);
      check("t4.bvalid_early", m_bvalid, 0);
      check("t4.s_awvalid", s_awvalid, 0);
      check("t4.s_wvalid", s_wvalid, 0);
      step();
      m_awvalid = 0; m_wvalid = 1; #1;
      check("t4.awready_done", m_awready, 0);
      check("t4.wready_open", m_wready, 1);
      check("t4.bvalid_mid", m_bvalid, 0);
      step();
      m_wvalid = 0; #1;
      check("t4.bvalid", m_bvalid, 1);
      check("t4.bresp", m_bresp, 2'b11);
      check("t4.wready_done", m_wready, 0);
      step(); #1;
      check("t4.bvalid_hold", m_bvalid, 1);
      m_bready = 1;
      step();
      m_bready = 0; #1;
      check("t4.bvalid_done", m_bvalid, 0);
      check("t4.bresp_idle", m_bresp, 0);

      // ---- multi-hit select routes to lowest index ----
      aw_slave_sel = 4'b0110; m_awvalid = 1; m_wvalid = 1;
      step();
      s_awready = 4'b0110; s_wready = 4'b0110; #1;
      check("t4m.s_awvalid", s_awvalid, 4'b0010);
      check("t4m.s_wvalid", s_wvalid, 4'b0010);
      check("t4m.awready", m_awready, 1);
      step();
      m_awvalid = 0; m_wvalid = 0; s_awready = '0; s_wready = '0; aw_slave_sel = '0;
      s_bvalid = 4'b0110; s_bresp = 8'b00_10_01_00; #1;
      check("t4m.bresp", m_bresp, 2'b01);
      m_bready = 1; #1;
      check("t4m.s_bready", s_bready, 4'b0010);
      step();
      m_bready = 0; s_bvalid = '0; s_bresp = '0; #1;
      check("t4m.aw_hs1", aw_hs[1], 2);
      check("t4m.aw_hs2", aw_hs[2], 1);
      check("t4m.w_hs2", w_hs[2], 1);

      // ---- concurrent read slave 0 / write slave 3 ----
      ar_slave_sel = 4'b0001; m_arvalid = 1;
      aw_slave_sel = 4'b1000; m_awvalid = 1; m_wvalid = 1;
      step(); #1;
      check("t5.s_arvalid", s_arvalid, 4'b0001);
      check("t5.s_awvalid", s_awvalid, 4'b1000);
      check("t5.s_wvalid", s_wvalid, 4'b1000);
      s_arready = 4'b0001; s_awready = 4'b1000; s_wready = 4'b1000; #1;
      check("t5.arready", m_arready, 1);
      check("t5.awready", m_awready, 1);
      step();
      m_arvalid = 0; m_awvalid = 0; m_wvalid = 0; ar_slave_sel = '0; aw_slave_sel = '0;
      s_arready = '0; s_awready = '0; s_wready = '0;
      s_rvalid = 4'b0001;
      s_rdata  = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hDEAD_BEEF};
      s_rresp  = 8'b10_10_10_00;
      s_bvalid = 4'b1001; s_bresp = 8'b00_11_11_10; #1;
      check("t5.rvalid", m_rvalid, 1);
      check("t5.rdata", m_rdata, 32'hDEAD_BEEF);
      check("t5.rresp", m_rresp, 2'b00);
      check("t5.bvalid", m_bvalid, 1);
      check("t5.bresp", m_bresp, 2'b00);
      m_rready = 1; m_bready = 1; #1;
      check("t5.s_rready", s_rready, 4'b0001);
      check("t5.s_bready", s_bready, 4'b1000);
      step();
      clear_inputs(); #1;
      check("t5.rvalid_done", m_rvalid, 0);
      check("t5.bvalid_done", m_bvalid, 0);
      check("t5.rdata_idle", m_rdata, 0);
      check("t5.ar_hs0", ar_hs[0], 1);
      check("t5.aw_hs3", aw_hs[3], 1);
      check("t5.w_hs3", w_hs[3], 1);
      check("t5.stray_ar", arv_cyc[1] + arv_cyc[2] + arv_cyc[3], 0);

      // ---- reset during WR_RESP ----
      aw_slave_sel = 4'b0001; m_awvalid = 1; m_wvalid = 1;
      step();
      s_awready = 4'b0001; s_wready = 4'b0001;
      step();
      m_awvalid = 0; m_wvalid = 0; s_awready = '0; s_wready = '0; aw_slave_sel = '0;
      s_bvalid = 4'b0001; s_bresp = 8'b11_11_11_01; #1;
      check("t6.bvalid_pre", m_bvalid, 1);
      check("t6.bresp_pre", m_bresp, 2'b01);
      m_bready = 1; m_awvalid = 1; m_wvalid = 1; #1;
      rst_n = 0; #1;
      check_all_zero("t6.reset");
      m_awvalid = 0; m_wvalid = 0;
      step(); step();
      rst_n = 1; #1;
      check("t6.no_resp", m_bvalid, 0);
      check("t6.no_bready", s_bready, 0);
      step(); #1;
      check("t6.no_resp_later", m_bvalid, 0);
      m_bready = 0; s_bvalid = '0; s_bresp = '0;
      aw_slave_sel = 4'b0001; m_awvalid = 1; m_wvalid = 1;
      step();
      s_awready = 4'b0001; s_wready = 4'b0001; #1;
      check("t6.awready", m_awready, 1);
      step();
      m_awvalid = 0; m_wvalid = 0; s_awready = '0; s_wready = '0; aw_slave_sel = '0;
      s_bvalid = 4'b0001; s_bresp = 8'b10_10_10_00; #1;
      check("t6.bvalid", m_bvalid, 1);
      check("t6.bresp", m_bresp, 2'b00);
      m_bready = 1;
      step();
      clear_inputs(); #1;
      check("t6.bvalid_done", m_bvalid, 0);
      check("t6.aw_hs0", aw_hs[0], 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
